decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  Parametrised decode/issue stage for the 5-stage ARM-subset core: decodes IF/ID instruction, reads register file
//  (sync write, write-through read), checks condition vs status reg, detects RAW hazards vs EX/MEM, registers result
//  into ID/EX pipeline register with stall/flush control. Sits between IF stage and EXE stage; counts hazard stalls.
// PARAMETERS
//  DATA_W      32  register / operand width
//  REG_COUNT   16  architectural registers; address width RA_W = $clog2(REG_COUNT) (4 at default)
//  PC_W        32  program counter width
//  FORWARD_EN   1  1: only load-use stalls (forwarding unit downstream); 0: stall on any EX/MEM RAW match
//  STALL_CNT_W 16  width of saturating hazard-stall counter
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       asynchronous active-high reset
//  if_valid     in   1       instruction/pc_in hold a valid fetched instruction
//  instruction  in   32      fetched word; cond[31:28] mode[27:26] I[25] op[24:21] S[20] Rn[19:16] Rd[15:12] Rm[3:0]
//  pc_in        in   PC_W    PC of fetched instruction
//  sr           in   4       status {N,Z,C,V}
//  wb_en        in   1       write-back enable;  wb_dest in RA_W;  wb_data in DATA_W
//  ex_wb_en, ex_mem_r_en in 1 / ex_dest in RA_W   instruction currently in EXE (driven from this block's own outputs)
//  mem_wb_en    in   1       / mem_dest in RA_W   instruction currently in MEM
//  ex_freeze    in   1       downstream stall: hold ID/EX register
//  flush        in   1       branch taken: squash instruction in ID
//  id_stall     out  1       combinational: IF must hold PC and IF/ID (hazard or ex_freeze)
//  out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_b, out_s   out 1 each  registered controls
//  out_exe_cmd  out  4       ALU command;  out_imm out 1 = I;  out_shift_op out 12;  out_imm24 out 24
//  out_val_rn, out_val_rm  out DATA_W;  out_dest, out_src1, out_src2 out RA_W;  out_pc out PC_W
//  stall_count  out  STALL_CNT_W  hazard-stall cycles since reset
// BEHAVIOUR
//  Decode (comb): mode 00: op MOV 1101->cmd 0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100,
//   SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000 (all wb=1); CMP 1010->0100, TST 1000->0110 (wb=0);
//   s=S. Undefined op: all controls 0. mode 01: S=1 LDR (wb, mem_r, cmd 0010); S=0 STR (mem_w, cmd 0010); s=0.
//   mode 10: b=1, all else 0. mode 11: all 0.
//  Condition: standard ARM codes 0000..1101 on {N,Z,C,V}; 1110 always; 1111 never. False -> controls 0.
//  Sources: src1=Rn, used unless MOV/MVN/branch; src2 = mem_w ? Rd : Rm; two_src = ~I | mem_w.
//  Regfile: REG_COUNT x DATA_W, async read, write on posedge when wb_en; read addr == wb_dest with wb_en returns
//   wb_data same cycle (write-through). Reset clears all to 0.
//  hazard = if_valid & cond_pass & RAW, RAW = (src used) & match vs EX (ex_wb_en & ex_dest) or MEM (mem_wb_en &
//   mem_dest); FORWARD_EN=1: only EX match with ex_mem_r_en counts, MEM ignored.
//  ID/EX update each posedge, priority: rst > ex_freeze (hold all) > flush (bubble) > hazard (bubble) > load decoded.
//   Bubble = out_valid and all control outputs 0, data fields don't-care (hold). out_valid = if_valid & cond_pass.
//  id_stall = (hazard & ~flush) | ex_freeze.
//  stall_count += 1 each cycle hazard & ~flush & ~ex_freeze; saturates at all-ones.
//  Reset: every out_* = 0, stall_count = 0, regfile = 0; reset mid-stall discards held instruction.
//  Latency: 1 cycle instruction -> out_*. Freeze+hazard together: hold, no count. Flush+hazard: bubble, no stall.
// TESTING
//  1 Reset: assert rst mid-stream -> all out_* 0, stall_count 0, R0..R15 read 0.
//  2 ADD R1,R2,R3 (0xE0821003), R2=5,R3=7 -> next cycle out_exe_cmd=0010, out_wb_en=1, val_rn=5, val_rm=7, dest=1.
//  3 Write-through: wb_en=1 wb_dest=2 wb_data=0x55 while decoding reader of R2 -> out_val_rn=0x55.
//  4 LDR R4,[R0] in EX (ex_mem_r_en=1,ex_dest=4) then ADD R5,R4,R1 -> id_stall=1 one cycle, bubble, count=1.
//  5 FORWARD_EN=0, SUB dest R4 in MEM then use R4 -> stall; FORWARD_EN=1 -> no stall.
//  6 ADDEQ with sr Z=0 -> out_valid=0 controls 0; flush with hazard -> bubble, id_stall=0; ex_freeze -> outputs hold.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: instruction decode, register file, condition check, RAW hazard detection
// and the ID/EX pipeline register with freeze/flush/stall handling.
module decode_issue_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_COUNT   = 16,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned FORWARD_EN  = 1,
    parameter int unsigned STALL_CNT_W = 16,
    localparam int unsigned RA_W       = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            instruction,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [3:0]             sr,
    input  logic                   wb_en,
    input  logic [RA_W-1:0]        wb_dest,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   ex_wb_en,
    input  logic                   ex_mem_r_en,
    input  logic [RA_W-1:0]        ex_dest,
    input  logic                   mem_wb_en,
    input  logic [RA_W-1:0]        mem_dest,
    input  logic                   ex_freeze,
    input  logic                   flush,
    output logic                   id_stall,
    output logic                   out_valid,
    output logic                   out_wb_en,
    output logic                   out_mem_r_en,
    output logic                   out_mem_w_en,
    output logic                   out_b,
    output logic                   out_s,
    output logic [3:0]             out_exe_cmd,
    output logic                   out_imm,
    output logic [11:0]            out_shift_op,
    output logic [23:0]            out_imm24,
    output logic [DATA_W-1:0]      out_val_rn,
    output logic [DATA_W-1:0]      out_val_rm,
    output logic [RA_W-1:0]        out_dest,
    output logic [RA_W-1:0]        out_src1,
    output logic [RA_W-1:0]        out_src2,
    output logic [PC_W-1:0]        out_pc,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpEor = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpAdc = 4'b0101;
    localparam logic [3:0] OpSbc = 4'b0110;
    localparam logic [3:0] OpTst = 4'b1000;
    localparam logic [3:0] OpCmp = 4'b1010;
    localparam logic [3:0] OpOrr = 4'b1100;
    localparam logic [3:0] OpMov = 4'b1101;
    localparam logic [3:0] OpMvn = 4'b1111;

    logic [3:0]      cond;
    logic [1:0]      mode;
    logic [3:0]      op;
    logic            i_bit;
    logic            s_bit;
    logic [RA_W-1:0] rn;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rm;
    logic [RA_W-1:0] src2;

    assign cond  = instruction[31:28];
    assign mode  = instruction[27:26];
    assign i_bit = instruction[25];
    assign op    = instruction[24:21];
    assign s_bit = instruction[20];
    assign rn    = RA_W'(instruction[19:16]);
    assign rd    = RA_W'(instruction[15:12]);
    assign rm    = RA_W'(instruction[3:0]);

    logic       dec_wb;
    logic       dec_mem_r;
    logic       dec_mem_w;
    logic       dec_b;
    logic       dec_s;
    logic       dec_no_rn;
    logic [3:0] dec_cmd;

    always_comb begin
        dec_wb    = 1'b0;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_b     = 1'b0;
        dec_s     = 1'b0;
        dec_no_rn = 1'b0;
        dec_cmd   = 4'b0000;
        case (mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = s_bit;
                case (op)
                    OpMov: begin
                        dec_cmd   = 4'b0001;
                        dec_no_rn = 1'b1;
                    end
                    OpMvn: begin
                        dec_cmd   = 4'b1001;
                        dec_no_rn = 1'b1;
                    end
                    OpAdd: dec_cmd = 4'b0010;
                    OpAdc: dec_cmd = 4'b0011;
                    OpSub: dec_cmd = 4'b0100;
                    OpSbc: dec_cmd = 4'b0101;
                    OpAnd: dec_cmd = 4'b0110;
                    OpOrr: dec_cmd = 4'b0111;
                    OpEor: dec_cmd = 4'b1000;
                    OpCmp: begin
                        dec_cmd = 4'b0100;
                        dec_wb  = 1'b0;
                    end
                    OpTst: begin
                        dec_cmd = 4'b0110;
                        dec_wb  = 1'b0;
                    end
                    default: begin
                        dec_wb = 1'b0;
                        dec_s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                // S selects load (1) versus store (0)
                dec_cmd   = 4'b0010;
                dec_wb    = s_bit;
                dec_mem_r = s_bit;
                dec_mem_w = ~s_bit;
            end
            2'b10: begin
                dec_b     = 1'b1;
                dec_no_rn = 1'b1;
            end
            default: ;
        endcase
    end

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = sr;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Stores read the data register through the second port
    assign src2 = dec_mem_w ? rd : rm;

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_dest] <= wb_data;
        end
    end

    assign val_rn = (wb_en && (wb_dest == rn))   ? wb_data : regs[rn];
    assign val_rm = (wb_en && (wb_dest == src2)) ? wb_data : regs[src2];

    logic use_rn;
    logic use_src2;
    logic ex_watch;
    logic mem_watch;
    logic raw;
    logic hazard;
    logic issue_en;

    // With forwarding downstream only a load in EX cannot be bypassed
    assign ex_watch  = ex_wb_en & ((FORWARD_EN == 0) | ex_mem_r_en);
    assign mem_watch = mem_wb_en & (FORWARD_EN == 0);
    assign use_rn    = ~dec_no_rn;
    assign use_src2  = ~i_bit | dec_mem_w;

    assign raw = (use_rn & ((ex_watch & (ex_dest == rn)) | (mem_watch & (mem_dest == rn))))
               | (use_src2 & ((ex_watch & (ex_dest == src2)) | (mem_watch & (mem_dest == src2))));

    assign issue_en = if_valid & cond_pass;
    assign hazard   = issue_en & raw;
    assign id_stall = (hazard & ~flush) | ex_freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_wb_en    <= 1'b0;
            out_mem_r_en <= 1'b0;
            out_mem_w_en <= 1'b0;
            out_b        <= 1'b0;
            out_s        <= 1'b0;
            out_exe_cmd  <= '0;
            out_imm      <= 1'b0;
            out_shift_op <= '0;
            out_imm24    <= '0;
            out_val_rn   <= '0;
            out_val_rm   <= '0;
            out_dest     <= '0;
            out_src1     <= '0;
            out_src2     <= '0;
            out_pc       <= '0;
        end else if (!ex_freeze) begin
            if (flush || hazard) begin
                // Bubble: controls cleared, data fields left as they were
                out_valid    <= 1'b0;
                out_wb_en    <= 1'b0;
                out_mem_r_en <= 1'b0;
                out_mem_w_en <= 1'b0;
                out_b        <= 1'b0;
                out_s        <= 1'b0;
                out_exe_cmd  <= '0;
            end else begin
                out_valid    <= issue_en;
                out_wb_en    <= issue_en & dec_wb;
                out_mem_r_en <= issue_en & dec_mem_r;
                out_mem_w_en <= issue_en & dec_mem_w;
                out_b        <= issue_en & dec_b;
                out_s        <= issue_en & dec_s;
                out_exe_cmd  <= issue_en ? dec_cmd : 4'b0000;
                out_imm      <= i_bit;
                out_shift_op <= instruction[11:0];
                out_imm24    <= instruction[23:0];
                out_val_rn   <= val_rn;
                out_val_rm   <= val_rm;
                out_dest     <= rd;
                out_src1     <= rn;
                out_src2     <= src2;
                out_pc       <= pc_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && !flush && !ex_freeze && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: table vectors, directed hazard/flush/freeze sequences and random
// traffic against a behavioural model, on instances with and without downstream forwarding.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic [3:0]  sr;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        ex_wb_en;
    logic        ex_mem_r_en;
    logic [3:0]  ex_dest;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;
    logic        ex_freeze;
    logic        flush;

    always #5 clk = ~clk;

    logic        d1_id_stall, d1_valid, d1_wb_en, d1_mem_r_en, d1_mem_w_en, d1_b, d1_s, d1_imm;
    logic [3:0]  d1_exe_cmd, d1_dest, d1_src1, d1_src2;
    logic [11:0] d1_shift_op;
    logic [23:0] d1_imm24;
    logic [31:0] d1_val_rn, d1_val_rm, d1_pc;
    logic [15:0] d1_stall_count;

    logic        d0_id_stall, d0_valid, d0_wb_en, d0_mem_r_en, d0_mem_w_en, d0_b, d0_s, d0_imm;
    logic [3:0]  d0_exe_cmd, d0_dest, d0_src1, d0_src2;
    logic [11:0] d0_shift_op;
    logic [23:0] d0_imm24;
    logic [31:0] d0_val_rn, d0_val_rm, d0_pc;
    logic [15:0] d0_stall_count;

    decode_issue_stage #(.FORWARD_EN(1)) dut1 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pc_in(pc_in),
        .sr(sr), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .ex_freeze(ex_freeze), .flush(flush), .id_stall(d1_id_stall), .out_valid(d1_valid),
        .out_wb_en(d1_wb_en), .out_mem_r_en(d1_mem_r_en), .out_mem_w_en(d1_mem_w_en),
        .out_b(d1_b), .out_s(d1_s), .out_exe_cmd(d1_exe_cmd), .out_imm(d1_imm),
        .out_shift_op(d1_shift_op), .out_imm24(d1_imm24), .out_val_rn(d1_val_rn),
        .out_val_rm(d1_val_rm), .out_dest(d1_dest), .out_src1(d1_src1), .out_src2(d1_src2),
        .out_pc(d1_pc), .stall_count(d1_stall_count)
    );

    decode_issue_stage #(.FORWARD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pc_in(pc_in),
        .sr(sr), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .ex_freeze(ex_freeze), .flush(flush), .id_stall(d0_id_stall), .out_valid(d0_valid),
        .out_wb_en(d0_wb_en), .out_mem_r_en(d0_mem_r_en), .out_mem_w_en(d0_mem_w_en),
        .out_b(d0_b), .out_s(d0_s), .out_exe_cmd(d0_exe_cmd), .out_imm(d0_imm),
        .out_shift_op(d0_shift_op), .out_imm24(d0_imm24), .out_val_rn(d0_val_rn),
        .out_val_rm(d0_val_rm), .out_dest(d0_dest), .out_src1(d0_src1), .out_src2(d0_src2),
        .out_pc(d0_pc), .stall_count(d0_stall_count)
    );

    logic [9:0]   act_ctl   [2];
    logic [144:0] act_dat   [2];
    logic [15:0]  act_cnt   [2];
    logic         act_stall [2];

    assign act_ctl[1] = {d1_valid, d1_wb_en, d1_mem_r_en, d1_mem_w_en, d1_b, d1_s, d1_exe_cmd};
    assign act_ctl[0] = {d0_valid, d0_wb_en, d0_mem_r_en, d0_mem_w_en, d0_b, d0_s, d0_exe_cmd};
    assign act_dat[1] = {d1_imm, d1_shift_op, d1_imm24, d1_val_rn, d1_val_rm, d1_dest, d1_src1,
                         d1_src2, d1_pc};
    assign act_dat[0] = {d0_imm, d0_shift_op, d0_imm24, d0_val_rn, d0_val_rm, d0_dest, d0_src1,
                         d0_src2, d0_pc};
    assign act_cnt[1]   = d1_stall_count;
    assign act_cnt[0]   = d0_stall_count;
    assign act_stall[1] = d1_id_stall;
    assign act_stall[0] = d0_id_stall;

    typedef struct packed {
        logic        valid, wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] imm24;
        logic [31:0] vrn, vrm;
        logic [3:0]  dest, src1, src2;
        logic [31:0] pc;
    } idex_t;

    typedef struct packed {
        logic       wb, mr, mw, b, s;
        logic [3:0] cmd;
    } dec_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [3:0]  sr;
        logic [9:0]  ctl;
    } vec_t;

    // Data-processing opcode table: MOV MVN ADD ADC SUB SBC AND ORR EOR CMP TST
    localparam logic [3:0] OpTab  [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1,
                                          4'hA, 4'h8};
    localparam logic [3:0] CmdTab [11] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                          4'h4, 4'h6};

    idex_t       exp_q [2];
    int unsigned cnt [2];
    logic [31:0] regs [16];
    int          checks = 0;
    int          errors = 0;

    task automatic cmp(input string nm, input logic [191:0] act, input logic [191:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [9:0] ctl_of(input idex_t e);
        return {e.valid, e.wb, e.mr, e.mw, e.b, e.s, e.cmd};
    endfunction

    function automatic logic [144:0] dat_of(input idex_t e);
        return {e.imm, e.shift, e.imm24, e.vrn, e.vrm, e.dest, e.src1, e.src2, e.pc};
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic dec_t model_dec(input logic [31:0] ins);
        dec_t d = '0;
        case (ins[27:26])
            2'b00: begin
                for (int i = 0; i < 11; i++) begin
                    if (OpTab[i] == ins[24:21]) begin
                        d.cmd = CmdTab[i];
                        d.wb  = (i < 9);
                        d.s   = ins[20];
                    end
                end
            end
            2'b01: begin
                d.cmd = 4'h2;
                if (ins[20]) begin
                    d.wb = 1'b1;
                    d.mr = 1'b1;
                end else begin
                    d.mw = 1'b1;
                end
            end
            2'b10: d.b = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic is_store(input logic [31:0] ins);
        return ins[27:26] == 2'b01 && !ins[20];
    endfunction

    function automatic logic [3:0] second_src(input logic [31:0] ins);
        return is_store(ins) ? ins[15:12] : ins[3:0];
    endfunction

    function automatic logic produced_by_pipe(input int fwd, input logic [3:0] r);
        logic ex_hit, mem_hit;
        ex_hit  = ex_wb_en && ex_dest == r && (fwd == 0 || ex_mem_r_en);
        mem_hit = fwd == 0 && mem_wb_en && mem_dest == r;
        return ex_hit || mem_hit;
    endfunction

    function automatic logic model_raw(input int fwd);
        logic reads_rn, reads_second;
        reads_rn = !(instruction[27:26] == 2'b10 ||
                     (instruction[27:26] == 2'b00 &&
                      (instruction[24:21] == 4'hD || instruction[24:21] == 4'hF)));
        reads_second = !instruction[25] || is_store(instruction);
        return (reads_rn && produced_by_pipe(fwd, instruction[19:16])) ||
               (reads_second && produced_by_pipe(fwd, second_src(instruction)));
    endfunction

    function automatic logic [31:0] read_reg(input logic [3:0] r);
        return (wb_en && wb_dest == r) ? wb_data : regs[r];
    endfunction

    task automatic check_outs();
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("ctl%0d", k), act_ctl[k], ctl_of(exp_q[k]));
            cmp($sformatf("data%0d", k), act_dat[k], dat_of(exp_q[k]));
            cmp($sformatf("count%0d", k), act_cnt[k], cnt[k]);
        end
    endtask

    task automatic tick();
        idex_t nxt [2];
        dec_t  d;
        logic  ok;
        logic  haz;
        #1;
        d  = model_dec(instruction);
        ok = if_valid && cond_ok(instruction[31:28], sr);
        for (int k = 0; k < 2; k++) begin
            haz = ok && model_raw(k);
            cmp($sformatf("id_stall%0d", k), act_stall[k], (haz && !flush) || ex_freeze);
            nxt[k] = exp_q[k];
            if (!ex_freeze) begin
                if (flush || haz) begin
                    nxt[k].valid = 1'b0;
                    nxt[k].wb    = 1'b0;
                    nxt[k].mr    = 1'b0;
                    nxt[k].mw    = 1'b0;
                    nxt[k].b     = 1'b0;
                    nxt[k].s     = 1'b0;
                    nxt[k].cmd   = 4'h0;
                    if (haz && !flush && cnt[k] != 32'hFFFF) cnt[k]++;
                end else begin
                    nxt[k].valid = ok;
                    {nxt[k].wb, nxt[k].mr, nxt[k].mw, nxt[k].b, nxt[k].s, nxt[k].cmd} =
                        ok ? d : '0;
                    nxt[k].imm   = instruction[25];
                    nxt[k].shift = instruction[11:0];
                    nxt[k].imm24 = instruction[23:0];
                    nxt[k].dest  = instruction[15:12];
                    nxt[k].src1  = instruction[19:16];
                    nxt[k].src2  = second_src(instruction);
                    nxt[k].vrn   = read_reg(instruction[19:16]);
                    nxt[k].vrm   = read_reg(second_src(instruction));
                    nxt[k].pc    = pc_in;
                end
            end
        end
        if (wb_en) regs[wb_dest] = wb_data;
        @(posedge clk);
        #1;
        exp_q = nxt;
        check_outs();
    endtask

    task automatic idle_inputs();
        if_valid    = 1'b0;
        instruction = 32'h0;
        pc_in       = 32'h0;
        sr          = 4'h0;
        wb_en       = 1'b0;
        wb_dest     = 4'h0;
        wb_data     = 32'h0;
        ex_wb_en    = 1'b0;
        ex_mem_r_en = 1'b0;
        ex_dest     = 4'h0;
        mem_wb_en   = 1'b0;
        mem_dest    = 4'h0;
        ex_freeze   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_q[k] = '0;
            cnt[k]   = 0;
        end
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        check_outs();
        cmp("rst_ctl", act_ctl[1], 10'h0);
        cmp("rst_data", act_dat[1], 145'h0);
        cmp("rst_count", d1_stall_count, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs [18];
        vecs[0]  = '{32'hE0821003, 4'h0, 10'b1100000010};  // ADD
        vecs[1]  = '{32'hE3B01005, 4'h0, 10'b1100010001};  // MOVS imm
        vecs[2]  = '{32'hE1E01002, 4'h0, 10'b1100001001};  // MVN
        vecs[3]  = '{32'hE0521003, 4'h0, 10'b1100010100};  // SUBS
        vecs[4]  = '{32'hE1520003, 4'h0, 10'b1000010100};  // CMP
        vecs[5]  = '{32'hE1120003, 4'h0, 10'b1000010110};  // TST
        vecs[6]  = '{32'hE0221003, 4'h0, 10'b1100001000};  // EOR
        vecs[7]  = '{32'hE4921000, 4'h0, 10'b1110000010};  // LDR
        vecs[8]  = '{32'hE4821000, 4'h0, 10'b1001000010};  // STR
        vecs[9]  = '{32'hEA000010, 4'h0, 10'b1000100000};  // B
        vecs[10] = '{32'hE0721003, 4'h0, 10'b1000000000};  // undefined opcode
        vecs[11] = '{32'hEC000000, 4'h0, 10'b1000000000};  // mode 11
        vecs[12] = '{32'h00821003, 4'h0, 10'b0000000000};  // ADDEQ, Z=0
        vecs[13] = '{32'h00821003, 4'h4, 10'b1100000010};  // ADDEQ, Z=1
        vecs[14] = '{32'hF0821003, 4'hF, 10'b0000000000};  // never
        vecs[15] = '{32'hC0821003, 4'h0, 10'b1100000010};  // GT
        vecs[16] = '{32'hB0821003, 4'h8, 10'b1100000010};  // LT, N!=V
        vecs[17] = '{32'h80821003, 4'h6, 10'b0000000000};  // HI, Z=1

        idle_inputs();
        apply_reset();

        for (int i = 0; i < 18; i++) begin
            idle_inputs();
            if_valid    = 1'b1;
            instruction = vecs[i].ins;
            sr          = vecs[i].sr;
            pc_in       = 32'h100 + 32'(i);
            tick();
            cmp($sformatf("vec%0d", i), act_ctl[1], vecs[i].ctl);
        end

        // Register reads and write-through
        idle_inputs();
        wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'd5;
        tick();
        wb_dest = 4'd3; wb_data = 32'd7;
        tick();
        wb_en = 1'b0; if_valid = 1'b1; instruction = 32'hE0821003;
        tick();
        cmp("add_rn", d1_val_rn, 32'd5);
        cmp("add_rm", d1_val_rm, 32'd7);
        cmp("add_dest", d1_dest, 4'd1);
        cmp("add_cmd", {d1_wb_en, d1_exe_cmd}, 5'b10010);
        wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'h55;
        tick();
        cmp("wt_rn", d1_val_rn, 32'h55);

        // Load-use: LDR R4 in EX, then ADD R5,R4,R1
        idle_inputs();
        apply_reset();
        ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_dest = 4'd4;
        if_valid = 1'b1; instruction = 32'hE0845001;
        #1;
        cmp("ldu_stall1", d1_id_stall, 1'b1);
        cmp("ldu_stall0", d0_id_stall, 1'b1);
        tick();
        cmp("ldu_bubble", d1_valid, 1'b0);
        cmp("ldu_count", d1_stall_count, 16'd1);
        ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd4;
        #1;
        cmp("ldu_release", d1_id_stall, 1'b0);
        tick();
        cmp("ldu_issue", {d1_valid, d1_dest}, 5'h15);
        cmp("ldu_count2", d1_stall_count, 16'd1);

        // MEM-stage producer only matters without forwarding
        idle_inputs();
        apply_reset();
        mem_wb_en = 1'b1; mem_dest = 4'd4; if_valid = 1'b1; instruction = 32'hE0845001;
        #1;
        cmp("mem_stall0", d0_id_stall, 1'b1);
        cmp("mem_stall1", d1_id_stall, 1'b0);
        tick();
        cmp("mem_valid0", d0_valid, 1'b0);
        cmp("mem_valid1", d1_valid, 1'b1);

        // Condition fail, flush over hazard, freeze over hazard
        idle_inputs();
        if_valid = 1'b1; instruction = 32'h00821003;
        tick();
        cmp("cfail", act_ctl[1], 10'h0);
        ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_dest = 4'd4; flush = 1'b1;
        instruction = 32'hE0845001;
        #1;
        cmp("flush_stall", d1_id_stall, 1'b0);
        tick();
        cmp("flush_valid", d1_valid, 1'b0);
        cmp("flush_count", d1_stall_count, 16'd0);
        idle_inputs();
        if_valid = 1'b1; instruction = 32'hE0821003;
        tick();
        ex_freeze = 1'b1; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_dest = 4'd4;
        instruction = 32'hE0845001;
        #1;
        cmp("frz_stall", d1_id_stall, 1'b1);
        tick();
        cmp("frz_hold", {d1_valid, d1_exe_cmd, d1_dest}, 9'h121);
        cmp("frz_count", d1_stall_count, 16'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            r[31:28] = ($urandom_range(3) != 0) ? 4'hE : 4'($urandom);
            r[19:16] = {1'b0, 3'($urandom)};
            r[15:12] = {1'b0, 3'($urandom)};
            r[3:0]   = {1'b0, 3'($urandom)};
            instruction = r;
            sr          = 4'($urandom);
            pc_in       = $urandom;
            if_valid    = $urandom_range(9) != 0;
            wb_en       = 1'($urandom);
            wb_dest     = {1'b0, 3'($urandom)};
            wb_data     = $urandom;
            ex_wb_en    = 1'($urandom);
            ex_mem_r_en = 1'($urandom);
            ex_dest     = {1'b0, 3'($urandom)};
            mem_wb_en   = 1'($urandom);
            mem_dest    = {1'b0, 3'($urandom)};
            flush       = $urandom_range(9) == 0;
            ex_freeze   = $urandom_range(9) == 0;
            tick();
        end

        // Reset mid-stream, then every register must read back as zero
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ri;
            ri = 4'(i);
            idle_inputs();
            if_valid    = 1'b1;
            instruction = {12'hE08, ri, 12'h000, ri};
            tick();
            cmp($sformatf("reg%0d_zero", i), {d1_val_rn, d1_val_rm}, 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
